// File: rtl/scan_mux.sv
// Registered N-channel data selector with manual select and dwell-timed round-robin scan.
// Optional macro SCAN_MUX_MASK_EN adds a per-channel mask that restricts which channels are scanned.
module scan_mux #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 1,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SCAN_MUX_MASK_EN
  input  logic [N-1:0]  mask,
`endif
  input  logic [N*W-1:0] I,
  input  logic [SW-1:0] S,
  input  logic          en,
  input  logic          mode,
  input  logic          load,
  output logic [W-1:0]  Y,
  output logic [SW-1:0] ch,
  output logic          valid,
  output logic          wrap
);

  typedef enum logic [1:0] {ST_IDLE, ST_MANUAL, ST_SCAN} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [7:0]    cnt_q, cnt_d, cnt_eff;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [N-1:0]  mask_eff;
  logic [SW-1:0] nxt_ch;

`ifdef SCAN_MUX_MASK_EN
  assign mask_eff = mask;
`else
  assign mask_eff = '1;
`endif

  // Out-of-range selects never match a channel and therefore read as zero.
  function automatic logic [W-1:0] pick(input logic [N*W-1:0] data, input logic [SW-1:0] sel);
    pick = '0;
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == sel) pick = data[k*W +: W];
    end
  endfunction

  // Lowest enabled channel above ch_q, else lowest enabled channel overall (wrap).
  always_comb begin
    nxt_ch = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_eff[k]) nxt_ch = SW'(k);
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_eff[k] && (SW'(k) > ch_q)) nxt_ch = SW'(k);
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (en) state_d = mode ? ST_SCAN : ST_MANUAL;

    // A fresh scan entry always starts its dwell from zero.
    cnt_eff = (state_q == ST_SCAN) ? cnt_q : 8'd0;

    y_d     = y_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    case (state_d)
      ST_MANUAL: begin
        ch_d    = S;
        y_d     = pick(I, S);
        cnt_d   = 8'd0;
        valid_d = 1'b1;
      end
      ST_SCAN: begin
        if (load) begin
          ch_d    = S;
          y_d     = pick(I, S);
          cnt_d   = 8'd0;
          valid_d = 1'b1;
        end
`ifdef SCAN_MUX_MASK_EN
        else if (mask == '0) begin
          cnt_d = 8'd0;
        end
`endif
        else if (cnt_eff == DWELL_LAST) begin
          ch_d    = nxt_ch;
          y_d     = pick(I, nxt_ch);
          cnt_d   = 8'd0;
          valid_d = 1'b1;
          wrap_d  = (nxt_ch <= ch_q);
        end else begin
          y_d     = pick(I, ch_q);
          cnt_d   = cnt_eff + 8'd1;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      ch_q    <= '0;
      cnt_q   <= 8'd0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y     = y_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: vector table, hand-written corner sequences, and randomized
// stimulus against a reference model, on an N=4 and an N=3 instance (W=8, DWELL=2).
module tb_scan_mux;

  logic clk = 1'b0;
  logic rst;

  logic [31:0] i4;
  logic [1:0]  s4, ch4;
  logic        en4, mode4, load4, valid4, wrap4;
  logic [7:0]  y4;

  logic [23:0] i3;
  logic [1:0]  s3, ch3;
  logic        en3, mode3, load3, valid3, wrap3;
  logic [7:0]  y3;

`ifdef SCAN_MUX_MASK_EN
  logic [3:0] mask4 = 4'hF;
  logic [2:0] mask3 = 3'h7;
`endif

  always #5 clk = ~clk;

  scan_mux #(.N(4), .W(8), .DWELL(2)) u_dut4 (
    .clk(clk), .rst(rst),
`ifdef SCAN_MUX_MASK_EN
    .mask(mask4),
`endif
    .I(i4), .S(s4), .en(en4), .mode(mode4), .load(load4),
    .Y(y4), .ch(ch4), .valid(valid4), .wrap(wrap4)
  );

  scan_mux #(.N(3), .W(8), .DWELL(2)) u_dut3 (
    .clk(clk), .rst(rst),
`ifdef SCAN_MUX_MASK_EN
    .mask(mask3),
`endif
    .I(i3), .S(s3), .en(en3), .mode(mode3), .load(load3),
    .Y(y3), .ch(ch3), .valid(valid3), .wrap(wrap3)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: channel position, dwell count and whether the previous cycle was a scan cycle.
  typedef struct {
    int ch;
    int y;
    int cnt;
    bit in_scan;
    bit valid;
    bit wrap;
  } mstate_t;

  function automatic mstate_t step(input mstate_t s, input int n, input int dwell, input int d[4],
                                   input bit en, input bit mode, input bit load, input int sel);
    mstate_t r;
    int c, nxt;
    r = s;
    r.valid = 0;
    r.wrap  = 0;
    if (!en) begin
      r.in_scan = 0;
    end else if (!mode) begin
      r.ch = sel;
      r.y = (sel < n) ? d[sel] : 0;
      r.cnt = 0;
      r.valid = 1;
      r.in_scan = 0;
    end else begin
      c = s.in_scan ? s.cnt : 0;
      r.in_scan = 1;
      r.valid = 1;
      if (load) begin
        r.ch = sel;
        r.y = (sel < n) ? d[sel] : 0;
        r.cnt = 0;
      end else if (c == dwell - 1) begin
        nxt = (s.ch >= n) ? 0 : (s.ch + 1) % n;
        r.wrap = (nxt <= s.ch);
        r.ch = nxt;
        r.y = d[nxt];
        r.cnt = 0;
      end else begin
        r.cnt = c + 1;
        r.y = (s.ch < n) ? d[s.ch] : 0;
      end
    end
    return r;
  endfunction

  typedef struct {
    bit         en;
    bit         mode;
    bit         load;
    logic [1:0] s;
    logic [7:0] y;
    logic [1:0] ch;
    bit         valid;
    bit         wrap;
  } vec_t;

  vec_t tbl[18];
  int   exp_ch[9]   = '{0, 1, 1, 2, 2, 3, 3, 0, 0};
  int   exp_wrap[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
  int   d4[4], d3[4];
  mstate_t m4, m3;

  initial begin
    // I = {44,33,22,11}: ch0=11, ch1=22, ch2=33, ch3=44; rows run straight on from reset.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h33, 2'd2, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h44, 2'd3, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h44, 2'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd3, 8'h44, 2'd3, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h44, 2'd3, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h11, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 2'd2, 8'h11, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h22, 2'd1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b1, 1'b0};

    i4 = 32'h44332211; s4 = 2'd0; en4 = 1'b0; mode4 = 1'b0; load4 = 1'b0;
    i3 = 24'hC3B2A1;   s3 = 2'd0; en3 = 1'b0; mode3 = 1'b0; load3 = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_y", 32'(y4), 32'h0);
    check("rst_ch", 32'(ch4), 32'h0);
    check("rst_valid", 32'(valid4), 32'h0);
    check("rst_wrap", 32'(wrap4), 32'h0);
    tick;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      en4 = tbl[i].en; mode4 = tbl[i].mode; load4 = tbl[i].load; s4 = tbl[i].s;
      tick;
      $display("vec %0d: en=%0b mode=%0b load=%0b S=%0d -> Y=%0h ch=%0d valid=%0b wrap=%0b",
               i, en4, mode4, load4, s4, y4, ch4, valid4, wrap4);
      check($sformatf("vec%0d_y", i), 32'(y4), 32'(tbl[i].y));
      check($sformatf("vec%0d_ch", i), 32'(ch4), 32'(tbl[i].ch));
      check($sformatf("vec%0d_valid", i), 32'(valid4), 32'(tbl[i].valid));
      check($sformatf("vec%0d_wrap", i), 32'(wrap4), 32'(tbl[i].wrap));
    end

    // Full scan cycle from reset, then async reset mid-dwell at ch=2.
    en4 = 1'b0; load4 = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    en4 = 1'b1; mode4 = 1'b1;
    for (int j = 0; j < 9; j++) begin
      tick;
      $display("scan %0d: ch=%0d Y=%0h wrap=%0b", j, ch4, y4, wrap4);
      check($sformatf("scan%0d_ch", j), 32'(ch4), 32'(exp_ch[j]));
      check($sformatf("scan%0d_wrap", j), 32'(wrap4), 32'(exp_wrap[j]));
      check($sformatf("scan%0d_y", j), 32'(y4), 32'(i4[exp_ch[j]*8 +: 8]));
    end
    repeat (3) tick;
    check("pre_arst_ch", 32'(ch4), 32'd2);
    #2 rst = 1'b1;
    #1;
    $display("async reset: Y=%0h ch=%0d valid=%0b", y4, ch4, valid4);
    check("arst_y", 32'(y4), 32'h0);
    check("arst_ch", 32'(ch4), 32'h0);
    check("arst_valid", 32'(valid4), 32'h0);
    tick;
    rst = 1'b0;
    tick;
    check("rel_ch0", 32'(ch4), 32'd0);
    check("rel_valid", 32'(valid4), 32'd1);
    tick;
    check("rel_ch1", 32'(ch4), 32'd1);
    $display("after release: ch=%0d Y=%0h", ch4, y4);

    // N=3 instance: out-of-range manual select, then scan entry from an out-of-range channel.
    en3 = 1'b1; mode3 = 1'b0; s3 = 2'd3;
    tick;
    $display("n3 manual S=3: Y=%0h ch=%0d valid=%0b", y3, ch3, valid3);
    check("n3_oor_y", 32'(y3), 32'h0);
    check("n3_oor_ch", 32'(ch3), 32'd3);
    check("n3_oor_valid", 32'(valid3), 32'd1);
    mode3 = 1'b1;
    tick;
    check("n3_entry_ch", 32'(ch3), 32'd3);
    check("n3_entry_y", 32'(y3), 32'h0);
    tick;
    $display("n3 advance: Y=%0h ch=%0d wrap=%0b", y3, ch3, wrap3);
    check("n3_adv_ch", 32'(ch3), 32'd0);
    check("n3_adv_y", 32'(y3), 32'hA1);
    check("n3_adv_wrap", 32'(wrap3), 32'd1);

    // Randomized run on both instances against the model.
    en4 = 1'b0; en3 = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m4 = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    m3 = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 300; c++) begin
      i4 = $urandom;
      i3 = 24'($urandom);
      en4 = ($urandom_range(0, 7) != 0); mode4 = ($urandom_range(0, 3) != 0);
      load4 = ($urandom_range(0, 5) == 0); s4 = 2'($urandom_range(0, 3));
      en3 = ($urandom_range(0, 7) != 0); mode3 = ($urandom_range(0, 3) != 0);
      load3 = ($urandom_range(0, 5) == 0); s3 = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) d4[k] = int'(i4[k*8 +: 8]);
      for (int k = 0; k < 3; k++) d3[k] = int'(i3[k*8 +: 8]);
      d3[3] = 0;
      m4 = step(m4, 4, 2, d4, en4, mode4, load4, int'(s4));
      m3 = step(m3, 3, 2, d3, en3, mode3, load3, int'(s3));
      tick;
      $display("rnd %0d: n4 ch=%0d Y=%0h v=%0b w=%0b | n3 ch=%0d Y=%0h v=%0b w=%0b",
               c, ch4, y4, valid4, wrap4, ch3, y3, valid3, wrap3);
      check("rnd4_y", 32'(y4), m4.y);
      check("rnd4_ch", 32'(ch4), m4.ch);
      check("rnd4_valid", 32'(valid4), 32'(m4.valid));
      check("rnd4_wrap", 32'(wrap4), 32'(m4.wrap));
      check("rnd3_y", 32'(y3), m3.y);
      check("rnd3_ch", 32'(ch3), m3.ch);
      check("rnd3_valid", 32'(valid3), 32'(m3.valid));
      check("rnd3_wrap", 32'(wrap3), 32'(m3.wrap));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
